// File: rtl/acf_axil_arbiter_if.sv
// Requester-side and AXI4-Lite master-side signal bundle for acf_axil_arbiter.
// The master modport is the arbiter's view; slave is the environment's view.
interface acf_axil_arbiter_if #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32
);
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;

  logic [1:0]      req_valid;
  logic [1:0]      req_wr;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]      req_ready;
  logic [1:0]      req_done;
  logic [DW-1:0]   rsp_rdata;
  logic [1:0]      rsp_resp;

  logic [AW-1:0]   m_axi_awaddr;
  logic [2:0]      m_axi_awprot;
  logic            m_axi_awvalid;
  logic            m_axi_awready;
  logic [DW-1:0]   m_axi_wdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic            m_axi_wvalid;
  logic            m_axi_wready;
  logic [1:0]      m_axi_bresp;
  logic            m_axi_bvalid;
  logic            m_axi_bready;
  logic [AW-1:0]   m_axi_araddr;
  logic [2:0]      m_axi_arprot;
  logic            m_axi_arvalid;
  logic            m_axi_arready;
  logic [DW-1:0]   m_axi_rdata;
  logic [1:0]      m_axi_rresp;
  logic            m_axi_rvalid;
  logic            m_axi_rready;

  modport master (
    input  req_valid, req_wr, req_addr, req_wdata,
    output req_ready, req_done, rsp_rdata, rsp_resp,
    output m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bresp, m_axi_bvalid,
    output m_axi_bready,
    output m_axi_araddr, m_axi_arprot, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    output m_axi_rready
  );

  modport slave (
    output req_valid, req_wr, req_addr, req_wdata,
    input  req_ready, req_done, rsp_rdata, rsp_resp,
    input  m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready,
    input  m_axi_araddr, m_axi_arprot, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    input  m_axi_rready
  );
endinterface

// File: rtl/acf_axil_arbiter.sv
// Two-requester AXI4-Lite master, one transaction in flight; accept->done >= 3 cycles, requests held off while busy.
// Round-robin by default; define ACF_AXIL_FIXED_PRIO_EN to make requester 0 always win.
module acf_axil_arbiter #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32
) (
  input  logic               m_axi_aclk,
  input  logic               m_axi_aresetn,
  acf_axil_arbiter_if.master bus
);
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WADDR,
    S_WRESP,
    S_RADDR,
    S_RDATA
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_armed;
  logic          r_owner;
  logic          r_aw_done;
  logic          r_w_done;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [1:0]    r_req_done;
  logic [DW-1:0] r_rdata;
  logic [1:0]    r_resp;

  logic          w_idle_ok;
  logic [1:0]    w_grant;
  logic          w_gnt_id;
  logic          w_awvalid;
  logic          w_wvalid;
  logic          w_aw_hs;
  logic          w_w_hs;

  // r_armed keeps req_ready low until the first edge after reset release;
  // the done cycle is also skipped so a new grant lands strictly after it.
  assign w_idle_ok = (r_state == S_IDLE) && r_armed && (r_req_done == 2'b00);

`ifdef ACF_AXIL_FIXED_PRIO_EN
  always_comb begin
    w_grant  = 2'b00;
    w_gnt_id = 1'b0;
    if (w_idle_ok) begin
      if (bus.req_valid[0]) begin
        w_grant  = 2'b01;
        w_gnt_id = 1'b0;
      end else if (bus.req_valid[1]) begin
        w_grant  = 2'b10;
        w_gnt_id = 1'b1;
      end
    end
  end
`else
  logic r_last;

  always_comb begin
    w_grant  = 2'b00;
    w_gnt_id = 1'b0;
    if (w_idle_ok) begin
      if (bus.req_valid == 2'b11) begin
        w_gnt_id = ~r_last;
        w_grant  = r_last ? 2'b01 : 2'b10;
      end else if (bus.req_valid[0]) begin
        w_grant  = 2'b01;
        w_gnt_id = 1'b0;
      end else if (bus.req_valid[1]) begin
        w_grant  = 2'b10;
        w_gnt_id = 1'b1;
      end
    end
  end

  // Reset value 1 makes requester 0 win the first contended grant.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      r_last <= 1'b1;
    end else if (w_grant != 2'b00) begin
      r_last <= w_gnt_id;
    end
  end
`endif

  assign w_awvalid = (r_state == S_WADDR) && !r_aw_done;
  assign w_wvalid  = (r_state == S_WADDR) && !r_w_done;
  assign w_aw_hs   = w_awvalid && bus.m_axi_awready;
  assign w_w_hs    = w_wvalid && bus.m_axi_wready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant != 2'b00) begin
          w_state_nxt = bus.req_wr[w_gnt_id] ? S_WADDR : S_RADDR;
        end
      end
      S_WADDR: begin
        if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
          w_state_nxt = S_WRESP;
        end
      end
      S_WRESP: begin
        if (bus.m_axi_bvalid) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RADDR: begin
        if (bus.m_axi_arready) begin
          w_state_nxt = S_RDATA;
        end
      end
      S_RDATA: begin
        if (bus.m_axi_rvalid) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      r_armed    <= 1'b0;
      r_owner    <= 1'b0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_req_done <= 2'b00;
      r_rdata    <= '0;
      r_resp     <= 2'b00;
    end else begin
      r_armed    <= 1'b1;
      r_req_done <= 2'b00;
      if (w_grant != 2'b00) begin
        r_owner   <= w_gnt_id;
        r_addr    <= w_gnt_id ? bus.req_addr[2*AW-1:AW] : bus.req_addr[AW-1:0];
        r_wdata   <= w_gnt_id ? bus.req_wdata[2*DW-1:DW] : bus.req_wdata[DW-1:0];
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if (w_aw_hs) begin
        r_aw_done <= 1'b1;
      end
      if (w_w_hs) begin
        r_w_done <= 1'b1;
      end
      if ((r_state == S_WRESP) && bus.m_axi_bvalid) begin
        r_resp     <= bus.m_axi_bresp;
        r_req_done <= r_owner ? 2'b10 : 2'b01;
      end
      if ((r_state == S_RDATA) && bus.m_axi_rvalid) begin
        r_rdata    <= bus.m_axi_rdata;
        r_resp     <= bus.m_axi_rresp;
        r_req_done <= r_owner ? 2'b10 : 2'b01;
      end
    end
  end

  assign bus.req_ready     = w_grant;
  assign bus.req_done      = r_req_done;
  assign bus.rsp_rdata     = r_rdata;
  assign bus.rsp_resp      = r_resp;

  assign bus.m_axi_awaddr  = r_addr;
  assign bus.m_axi_awprot  = 3'b000;
  assign bus.m_axi_awvalid = w_awvalid;
  assign bus.m_axi_wdata   = r_wdata;
  assign bus.m_axi_wstrb   = (r_state == S_WADDR) ? {SW{1'b1}} : {SW{1'b0}};
  assign bus.m_axi_wvalid  = w_wvalid;
  assign bus.m_axi_bready  = (r_state == S_WRESP);
  assign bus.m_axi_araddr  = r_addr;
  assign bus.m_axi_arprot  = 3'b000;
  assign bus.m_axi_arvalid = (r_state == S_RADDR);
  assign bus.m_axi_rready  = (r_state == S_RDATA);
endmodule

// File: tb/tb_acf_axil_arbiter.sv
// Scoreboard bench for acf_axil_arbiter: directed transactions push expected completions,
// a monitor pops and compares them whenever req_done pulses.
module tb_acf_axil_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   dones = 0;

  acf_axil_arbiter_if #(.C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW)) bus();

  acf_axil_arbiter #(.C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW)) dut (
    .m_axi_aclk    (clk),
    .m_axi_aresetn (rst_n),
    .bus           (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          id;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          aw_d;
    int          w_d;
    int          b_d;
    int          ar_d;
    int          r_d;
    logic [1:0]  s_resp;
    logic [31:0] s_rdata;
    logic [31:0] exp_rdata;
    int          lat;
    int          n_aw;
    int          n_w;
    int          n_rsp;
  } vec_t;

  typedef struct {
    int          id;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          acc;
    int          lat;
    int          n_aw;
    int          n_w;
    int          n_rsp;
  } exp_t;

  exp_t sb_q[$];

  int          c_aw = 0, c_w = 0, c_b = 0, c_ar = 0, c_r = 0;
  logic [1:0]  c_resp = 2'b00;
  logic [31:0] c_rdata = 32'h0;
  logic [31:0] s_addr = 32'h0;
  logic [31:0] s_wdata = 32'h0;
  logic [3:0]  s_wstrb = 4'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // AXI4-Lite slave: each ready/valid asserts after a configured number of cycles.
  initial begin
    int ca, cw, cb, car, cr;
    ca = 0; cw = 0; cb = 0; car = 0; cr = 0;
    bus.m_axi_awready = 1'b0;
    bus.m_axi_wready  = 1'b0;
    bus.m_axi_bvalid  = 1'b0;
    bus.m_axi_bresp   = 2'b00;
    bus.m_axi_arready = 1'b0;
    bus.m_axi_rvalid  = 1'b0;
    bus.m_axi_rresp   = 2'b00;
    bus.m_axi_rdata   = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.m_axi_awvalid) begin
        bus.m_axi_awready = (ca == c_aw);
        if (ca == c_aw) s_addr = bus.m_axi_awaddr;
        ca++;
      end else begin
        bus.m_axi_awready = 1'b0;
        ca = 0;
      end
      if (bus.m_axi_wvalid) begin
        bus.m_axi_wready = (cw == c_w);
        if (cw == c_w) begin
          s_wdata = bus.m_axi_wdata;
          s_wstrb = bus.m_axi_wstrb;
        end
        cw++;
      end else begin
        bus.m_axi_wready = 1'b0;
        cw = 0;
      end
      if (bus.m_axi_arvalid) begin
        bus.m_axi_arready = (car == c_ar);
        if (car == c_ar) s_addr = bus.m_axi_araddr;
        car++;
      end else begin
        bus.m_axi_arready = 1'b0;
        car = 0;
      end
      if (bus.m_axi_bready) begin
        bus.m_axi_bvalid = (cb == c_b);
        bus.m_axi_bresp  = c_resp;
        cb++;
      end else begin
        bus.m_axi_bvalid = 1'b0;
        cb = 0;
      end
      if (bus.m_axi_rready) begin
        bus.m_axi_rvalid = (cr == c_r);
        bus.m_axi_rresp  = c_resp;
        bus.m_axi_rdata  = c_rdata;
        cr++;
      end else begin
        bus.m_axi_rvalid = 1'b0;
        cr = 0;
      end
    end
  end

  // Monitor: counts channel activity per transaction and scores each completion.
  initial begin
    int   n_aw, n_w, n_rsp;
    exp_t e;
    n_aw = 0; n_w = 0; n_rsp = 0;
    forever begin
      @(negedge clk);
      if (!rst_n || (bus.req_ready != 2'b00)) begin
        n_aw = 0; n_w = 0; n_rsp = 0;
      end else begin
        if (bus.m_axi_awvalid) n_aw++;
        if (bus.m_axi_wvalid) n_w++;
        if (bus.m_axi_bready || bus.m_axi_rready) n_rsp++;
        if (bus.req_done != 2'b00) begin
          dones++;
          if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done actual=%b required=none", bus.req_done);
          end else begin
            e = sb_q.pop_front();
            chk("done_owner", {62'h0, bus.req_done}, (e.id == 1) ? 64'h2 : 64'h1);
            chk("rsp_resp", {62'h0, bus.rsp_resp}, {62'h0, e.resp});
            chk("rsp_rdata", {32'h0, bus.rsp_rdata}, {32'h0, e.rdata});
            chk("axi_addr", {32'h0, s_addr}, {32'h0, e.addr});
            chk("latency", 64'(cyc - e.acc), 64'(e.lat));
            chk("awvalid_cycles", 64'(n_aw), 64'(e.n_aw));
            chk("wvalid_cycles", 64'(n_w), 64'(e.n_w));
            chk("rsp_ready_cycles", 64'(n_rsp), 64'(e.n_rsp));
            if (e.wr) begin
              chk("axi_wdata", {32'h0, s_wdata}, {32'h0, e.wdata});
              chk("axi_wstrb", {60'h0, s_wstrb}, 64'hF);
            end
          end
        end
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=pending%0d required=0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic run_txn(input vec_t v, input bit wait_done);
    bit   got;
    exp_t e;
    c_aw = v.aw_d; c_w = v.w_d; c_b = v.b_d; c_ar = v.ar_d; c_r = v.r_d;
    c_resp = v.s_resp; c_rdata = v.s_rdata;
    @(posedge clk);
    #1;
    bus.req_wr[v.id]               = v.wr;
    bus.req_addr[v.id*AW +: AW]    = v.addr;
    bus.req_wdata[v.id*DW +: DW]   = v.wdata;
    bus.req_valid[v.id]            = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (bus.req_ready[v.id]) got = 1'b1;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=no_ready required=req_ready[%0d]", v.id);
    end else begin
      e = '{v.id, v.wr, v.addr, v.wdata, v.exp_rdata, v.s_resp, cyc, v.lat, v.n_aw, v.n_w, v.n_rsp};
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.req_valid[v.id] = 1'b0;
    if (wait_done) wait_idle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t vt[8];
  int   exp_seq[4];

  initial begin
    bit   got;
    exp_t e;
    vt[0] = '{0, 1'b1, 32'h0,  32'h5,        0, 0, 0, 0, 0, 2'b00, 32'h0,        32'h0,        3, 1, 1, 1};
    vt[1] = '{1, 1'b1, 32'h8,  32'h1234,     2, 0, 0, 0, 0, 2'b00, 32'h0,        32'h0,        5, 3, 1, 1};
    vt[2] = '{1, 1'b0, 32'h4,  32'h0,        0, 0, 0, 0, 3, 2'b00, 32'hDEADBEEF, 32'hDEADBEEF, 6, 0, 0, 4};
    vt[3] = '{0, 1'b1, 32'hC,  32'hA5A5A5A5, 0, 0, 1, 0, 0, 2'b10, 32'h0,        32'hDEADBEEF, 4, 1, 1, 2};
    vt[4] = '{0, 1'b0, 32'h10, 32'h0,        0, 0, 0, 1, 0, 2'b00, 32'hCAFE0001, 32'hCAFE0001, 4, 0, 0, 1};
    vt[5] = '{0, 1'b1, 32'h14, 32'h77,       0, 0, 3, 0, 0, 2'b00, 32'h0,        32'hCAFE0001, 6, 1, 1, 4};
    vt[6] = '{0, 1'b0, 32'h20, 32'h0,        0, 0, 0, 0, 0, 2'b00, 32'h0BADF00D, 32'h0BADF00D, 3, 0, 0, 1};
    vt[7] = '{0, 1'b1, 32'h30, 32'h99,       0, 0, 5, 0, 0, 2'b00, 32'h0,        32'h0,        8, 1, 1, 6};
`ifdef ACF_AXIL_FIXED_PRIO_EN
    exp_seq = '{0, 0, 0, 0};
`else
    exp_seq = '{0, 1, 0, 1};
`endif

    // Reset state, with both requesters already asking.
    bus.req_valid = 2'b11;
    bus.req_wr    = 2'b11;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    #12;
    chk("rst_req_ready", {62'h0, bus.req_ready}, 64'h0);
    chk("rst_req_done", {62'h0, bus.req_done}, 64'h0);
    chk("rst_valids", {59'h0, bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready,
                       bus.m_axi_arvalid, bus.m_axi_rready}, 64'h0);
    chk("rst_rsp", {30'h0, bus.rsp_resp, bus.rsp_rdata}, 64'h0);
    chk("rst_addr", {bus.m_axi_awaddr, bus.m_axi_araddr}, 64'h0);
    chk("rst_wdata_strb", {28'h0, bus.m_axi_wstrb, bus.m_axi_wdata}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_before_first_edge", {62'h0, bus.req_ready}, 64'h0);
    bus.req_valid = 2'b00;

    for (int i = 0; i < 5; i++) run_txn(vt[i], 1'b1);

    // A request raised while busy must be ignored and produce no completion.
    run_txn(vt[5], 1'b0);
    bus.req_wr[1]    = 1'b0;
    bus.req_valid[1] = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("busy_no_ready", {62'h0, bus.req_ready}, 64'h0);
    end
    @(posedge clk);
    #1;
    bus.req_valid[1] = 1'b0;
    wait_idle();

    // Reset in the middle of a write response.
    run_txn(vt[7], 1'b0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.m_axi_bready) got = 1'b1;
    end
    chk("reached_wresp", {63'h0, got}, 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {60'h0, bus.m_axi_bready, bus.m_axi_awvalid, bus.m_axi_wvalid,
                           1'b0}, 64'h0);
    chk("midrst_done", {62'h0, bus.req_done}, 64'h0);
    sb_q.delete();
    bus.req_wr[0]    = 1'b0;
    bus.req_valid[0] = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_ready", {62'h0, bus.req_ready}, 64'h0);
    chk("midrst_rsp", {30'h0, bus.rsp_resp, bus.rsp_rdata}, 64'h0);
    #1;
    rst_n = 1'b1;
    #1;
    chk("ready_after_release", {62'h0, bus.req_ready}, 64'h0);
    bus.req_valid = 2'b00;
    run_txn(vt[6], 1'b1);

    // Contended writes from a fresh reset.
    do_reset();
    c_aw = 0; c_w = 0; c_b = 0; c_ar = 0; c_r = 0; c_resp = 2'b00;
    bus.req_wr    = 2'b11;
    bus.req_addr  = {32'h200, 32'h100};
    bus.req_wdata = {32'h2, 32'h1};
    @(posedge clk);
    #1;
    bus.req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
        @(negedge clk);
        if (bus.req_ready != 2'b00) got = 1'b1;
      end
      chk("grant_seq", {62'h0, bus.req_ready}, (exp_seq[k] == 1) ? 64'h2 : 64'h1);
      e = '{exp_seq[k], 1'b1, (exp_seq[k] == 1) ? 32'h200 : 32'h100,
            (exp_seq[k] == 1) ? 32'h2 : 32'h1, 32'h0, 2'b00, cyc, 3, 1, 1, 1};
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 2'b00;
    wait_idle();

    repeat (3) @(negedge clk);
    chk("done_count", 64'(dones), 64'd11);
    chk("queue_empty", 64'(sb_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/acf_axil_arbiter.md
ACF_AXIL_ARBITER -- requirements
Module: acf_axil_arbiter

Interface
REQ-001 Parameter C_M_AXI_ADDR_WIDTH, default 32, AXI4-Lite address width.
REQ-002 Parameter C_M_AXI_DATA_WIDTH, default 32, AXI4-Lite data width; only 32 supported.
REQ-003 m_axi_aclk  in  1  sole clock; all logic rising-edge.
REQ-004 m_axi_aresetn  in  1  asynchronous active-low reset.
REQ-005 req_valid  in  2  per-requester transaction request, bit i = requester i.
REQ-006 req_wr  in  2  per-requester direction: 1 write, 0 read.
REQ-007 req_addr  in  2*ADDR  per-requester address, requester i at bits [i*ADDR +: ADDR].
REQ-008 req_wdata  in  2*DATA  per-requester write data, same packing.
REQ-009 req_ready  out  2  one-cycle accept pulse to granted requester.
REQ-010 req_done  out  2  one-cycle completion pulse to owning requester.
REQ-011 rsp_rdata  out  DATA  read data, valid with req_done.
REQ-012 rsp_resp  out  2  BRESP/RRESP of completed transaction, valid with req_done.
REQ-013 m_axi_aw*  awaddr/awprot/awvalid out, awready in; AXI4-Lite write address channel.
REQ-014 m_axi_w*  wdata/wstrb/wvalid out, wready in; write data channel.
REQ-015 m_axi_b*  bresp/bvalid in, bready out; write response channel.
REQ-016 m_axi_ar*  araddr/arprot/arvalid out, arready in; read address channel.
REQ-017 m_axi_r*  rdata/rresp/rvalid in, rready out; read data channel.

Function
REQ-018 FSM states IDLE, WADDR, WRESP, RADDR, RDATA; exactly one AXI transaction outstanding.
REQ-019 IDLE: any req_valid set -> grant one requester, pulse req_ready[g], latch its wr/addr/wdata, go WADDR (wr=1) or RADDR (wr=0) next cycle.
REQ-020 Arbitration round-robin: both valid -> grant requester not granted last; pointer updates only on grant.
REQ-021 WADDR: awvalid and wvalid asserted together in first WADDR cycle; each deasserts independently on its own valid&ready edge; leaves to WRESP once both handshakes done (same or different cycles).
REQ-022 wstrb SHALL be 4'hF during WADDR, 0 otherwise; awprot and arprot constant 3'b000.
REQ-023 WRESP: bready=1; on bvalid&bready capture bresp, pulse req_done[g], return IDLE.
REQ-024 RADDR: arvalid=1 until arvalid&arready, then RDATA.
REQ-025 RDATA: rready=1; on rvalid&rready capture rdata/rresp, pulse req_done[g], return IDLE.
REQ-026 Valids never drop before handshake; addr/data/strb stable while valid high.
REQ-027 Minimum latency accept->done: 3 cycles (IDLE grant, 1-cycle address/data handshake, 1-cycle response).
REQ-028 New grant earliest in the cycle after req_done; req_valid seen during busy states ignored until IDLE.
REQ-029 Requester deasserting req_valid before req_ready: no grant, no side effect.
REQ-030 rsp_rdata/rsp_resp hold last captured value until next completion; rsp_rdata unchanged by writes.

Reset
REQ-031 m_axi_aresetn low SHALL immediately force state IDLE and all valid/ready/pulse outputs 0, including mid-transaction.
REQ-032 Reset values: rsp_rdata 0, rsp_resp 2'b00, awaddr/araddr/wdata 0, wstrb 0, round-robin pointer favouring requester 0.
REQ-033 Outputs first change on the first rising edge after m_axi_aresetn deasserts.

Configuration
REQ-034 Macro ACF_AXIL_FIXED_PRIO_EN defined: requester 0 always wins simultaneous requests, no pointer kept.
REQ-035 Macro undefined: round-robin per REQ-020.

Verification
REQ-036 Req0 write addr 0x0 data 0x5, slave awready/wready same cycle, bresp 00 -> awvalid,wvalid,bready each 1 cycle, req_done=2'b01 three cycles after req_ready, rsp_resp 00.
REQ-037 Req1 write, slave asserts wready 2 cycles before awready -> wvalid drops after its handshake, awvalid holds until its handshake, single req_done[1].
REQ-038 Req1 read addr 0x4, slave returns rdata 0xDEADBEEF rresp 00 after 3-cycle rvalid delay -> rready held, rsp_rdata 0xDEADBEEF with req_done=2'b10.
REQ-039 Both requesters valid continuously, 4 writes -> grants 0,1,0,1 (macro undefined); 0,0,0,0 (ACF_AXIL_FIXED_PRIO_EN defined).
REQ-040 Reset asserted while in WRESP with bvalid low -> bready, awvalid, wvalid, req_done all 0 immediately; after release, fresh req0 read completes normally.
REQ-041 Slave bresp 2'b10 on write -> rsp_resp 2'b10 with req_done, rsp_rdata unchanged.
